// File: rtl/adder_pkg.sv
// Shared state encodings and elaboration helpers for the digit-serial add/subtract unit.
package adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >>> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/digit_adder.sv
// Combinational DIGIT-bit ripple adder; also exposes the carry into its top bit for overflow.
module digit_adder #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             ci,
    output logic [DIGIT-1:0] s,
    output logic             co,
    output logic             c_msb
);

    logic [DIGIT:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < DIGIT; i++) begin : g_bit
        assign s[i]   = x[i] ^ y[i] ^ c[i];
        assign c[i+1] = (x[i] & y[i]) | (x[i] & c[i]) | (y[i] & c[i]);
    end

    assign co    = c[DIGIT];
    assign c_msb = c[DIGIT-1];

endmodule

// File: rtl/addsub_digit_serial.sv
// Digit-serial add/subtract: DIGIT bits per cycle with the inter-digit carry held in a register.
module addsub_digit_serial
    import adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int NDIG  = WIDTH / ((DIGIT < 1) ? 1 : DIGIT);
    localparam int IDX_W = (NDIG > 1) ? clog2(NDIG) : 1;

    if ((DIGIT < 1) || ((WIDTH % ((DIGIT < 1) ? 1 : DIGIT)) != 0)) begin : g_bad_params
        $fatal(1, "addsub_digit_serial: WIDTH must be a positive multiple of DIGIT");
    end

    state_t             state_q;
    logic [IDX_W-1:0]   idx_q;
    logic [WIDTH-1:0]   opa_q;
    logic [WIDTH-1:0]   opb_q;
    logic               carry_q;
    logic [WIDTH-1:0]   acc_q;
    logic [WIDTH-1:0]   acc_d;
    logic [WIDTH-1:0]   sum_q;
    logic               cout_q;
    logic               ovf_q;
    logic               zero_q;

    logic [DIGIT-1:0]       dig_s;
    logic                   dig_co;
    logic                   dig_cmsb;
    logic [WIDTH+DIGIT-1:0] acc_cat;
    logic                   last_dig;

    digit_adder #(.DIGIT(DIGIT)) u_digit_adder (
        .x     (opa_q[DIGIT-1:0]),
        .y     (opb_q[DIGIT-1:0]),
        .ci    (carry_q),
        .s     (dig_s),
        .co    (dig_co),
        .c_msb (dig_cmsb)
    );

    // New digit enters from the top so the first digit ends up at the bottom after NDIG shifts.
    assign acc_cat  = {dig_s, acc_q};
    assign acc_d    = acc_cat[WIDTH+DIGIT-1:DIGIT];
    assign last_dig = (idx_q == IDX_W'(NDIG - 1));

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;

    always_ff @(posedge clk) begin
        if (state_q == ST_IDLE) begin
            opa_q   <= a;
            opb_q   <= sub ? ~b : b;
            carry_q <= sub ? 1'b1 : cin;
        end else if (state_q == ST_RUN) begin
            opa_q   <= opa_q >> DIGIT;
            opb_q   <= opb_q >> DIGIT;
            carry_q <= dig_co;
            acc_q   <= acc_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        state_q <= ST_RUN;
                        idx_q   <= '0;
                    end
                end
                ST_RUN: begin
                    idx_q <= idx_q + IDX_W'(1);
                    if (last_dig) begin
                        state_q <= ST_DONE;
                        sum_q   <= acc_d;
                        cout_q  <= dig_co;
                        ovf_q   <= dig_cmsb ^ dig_co;
                        zero_q  <= (acc_d == '0);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule
